// File: rtl/cordic_vectoring.sv
// Iterative CORDIC in vectoring mode: rotates (x, y) onto the positive x axis,
// producing the gain-scaled magnitude and atan2(y, x) after ITER micro-rotations.
module cordic_vectoring #(
  parameter int WIDTH = 32,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH+1:0] magnitude,
  output logic signed [WIDTH-1:0] angle
);

  localparam int XW   = WIDTH + 2;
  localparam int IW   = $clog2(ITER + 1);
  localparam int FRAC = WIDTH - 5;

  // atan(2^-i) in radians scaled by 2^30; rescaled to the angle format below.
  function automatic logic [31:0] atan_q30(input logic [4:0] idx);
    case (idx)
      5'd0:  return 32'h3243F6A8;
      5'd1:  return 32'h1DAC6705;
      5'd2:  return 32'h0FADBAFC;
      5'd3:  return 32'h07F56EA6;
      5'd4:  return 32'h03FEAB76;
      5'd5:  return 32'h01FFD55B;
      5'd6:  return 32'h00FFFAAA;
      5'd7:  return 32'h007FFF55;
      5'd8:  return 32'h003FFFEA;
      5'd9:  return 32'h001FFFFD;
      5'd10: return 32'h000FFFFF;
      5'd11: return 32'h0007FFFF;
      5'd12: return 32'h0003FFFF;
      5'd13: return 32'h0001FFFF;
      5'd14: return 32'h0000FFFF;
      5'd15: return 32'h00007FFF;
      5'd16: return 32'h00003FFF;
      5'd17: return 32'h00001FFF;
      5'd18: return 32'h00000FFF;
      5'd19: return 32'h000007FF;
      5'd20: return 32'h000003FF;
      5'd21: return 32'h000001FF;
      5'd22: return 32'h000000FF;
      5'd23: return 32'h0000007F;
      5'd24: return 32'h0000003F;
      5'd25: return 32'h0000001F;
      5'd26: return 32'h0000000F;
      5'd27: return 32'h00000008;
      5'd28: return 32'h00000004;
      5'd29: return 32'h00000002;
      5'd30: return 32'h00000001;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic signed [WIDTH-1:0] to_angle(input logic [31:0] q30);
    return WIDTH'({q30, 64'd0} >> (94 - FRAC));
  endfunction

  localparam logic signed [WIDTH-1:0] PI     = to_angle(32'hC90FDAA0);
  localparam logic signed [WIDTH-1:0] NEG_PI = -PI;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic [IW-1:0]           i_q, i_d;
  logic                    zero_q, zero_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic signed [XW-1:0]    mag_q, mag_d;
  logic signed [WIDTH-1:0] ang_q, ang_d;

  logic signed [XW-1:0]    x_ext_s, y_ext_s, x_sh_s, y_sh_s;
  logic signed [WIDTH-1:0] atan_s;

  assign x_ext_s = {{2{x_in[WIDTH-1]}}, x_in};
  assign y_ext_s = {{2{y_in[WIDTH-1]}}, y_in};
  assign x_sh_s  = x_q >>> i_q;
  assign y_sh_s  = y_q >>> i_q;
  assign atan_s  = to_angle(atan_q30(5'(i_q)));

  // Next-state, micro-rotation datapath and output register loads.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    zero_d  = zero_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    mag_d   = mag_q;
    ang_d   = ang_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ITER;
          busy_d  = 1'b1;
          i_d     = {IW{1'b0}};
          zero_d  = (x_in == {WIDTH{1'b0}}) && (y_in == {WIDTH{1'b0}});
          // Left half-plane vectors are reflected through the origin first.
          if (!x_in[WIDTH-1]) begin
            x_d = x_ext_s;
            y_d = y_ext_s;
            z_d = {WIDTH{1'b0}};
          end else begin
            x_d = -x_ext_s;
            y_d = -y_ext_s;
            z_d = y_in[WIDTH-1] ? NEG_PI : PI;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (!y_q[XW-1]) begin
          x_d = x_q + y_sh_s;
          y_d = y_q - x_sh_s;
          z_d = z_q + atan_s;
        end else begin
          x_d = x_q - y_sh_s;
          y_d = y_q + x_sh_s;
          z_d = z_q - atan_s;
        end
        i_d = i_q + IW'(1);
        if (i_q == IW'(ITER - 1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end else begin
          busy_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        mag_d   = x_q;
        if (zero_q) begin
          ang_d = {WIDTH{1'b0}};
        end else if (z_q > PI) begin
          ang_d = PI;
        end else if (z_q < NEG_PI) begin
          ang_d = NEG_PI;
        end else begin
          ang_d = z_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= {XW{1'b0}};
      y_q     <= {XW{1'b0}};
      z_q     <= {WIDTH{1'b0}};
      i_q     <= {IW{1'b0}};
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mag_q   <= {XW{1'b0}};
      ang_q   <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign magnitude = mag_q;
  assign angle     = ang_q;

endmodule
